// File: rtl/sm_display_scanner.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// Scans DIGITS digits one slot at a time. Each slot is 16 scan ticks long:
// a blank interval, then a PWM on-window set by brightness, then off time.
// Display data is shadowed once per frame so a frame never mixes old and new digits.
// Optional: define SM_SCAN_LEADING_ZERO_BLANK_EN to keep leading zero digits dark.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | disabled; display dark, prescaler/slot/digit counters held at 0
// BLANK | start of slot, all anodes off (anti-ghosting)
// ON    | selected digit lit for the latched on-time
// OFF   | rest of slot, all anodes off
module sm_display_scanner #(
   parameter int DIGITS      = 4,
   parameter int SCAN_DIV    = 1024,
   parameter int BLANK_TICKS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [DIGITS*4-1:0]       value,
   input  logic [DIGITS-1:0]         dpMask,
   input  logic [3:0]                brightness,
   output logic [6:0]                segments,
   output logic                      dp,
   output logic [DIGITS-1:0]         anodes,
   output logic [$clog2(DIGITS)-1:0] digitIndex,
   output logic                      frameStart
);

   localparam int IW = $clog2(DIGITS);
   localparam int PW = $clog2(SCAN_DIV);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_ON    = 2'd2;
   localparam logic [1:0] S_OFF   = 2'd3;

   localparam logic [4:0] BT    = 5'(BLANK_TICKS);
   localparam logic [4:0] MAX_L = 5'(16 - BLANK_TICKS);

   logic [1:0]          state_q, state_n;
   logic [PW-1:0]       presc_q, presc_n;
   logic [3:0]          slot_q, slot_n;
   logic [IW-1:0]       dig_q, dig_n;
   logic [4:0]          len_q, len_n, len_in;
   logic [DIGITS*4-1:0] val_q, val_n;
   logic [DIGITS-1:0]   dpm_q, dpm_n;
   logic                fs_n, tick, last_dig;
   logic [6:0]          seg_n, seg_dec;
   logic [DIGITS-1:0]   an_n;
   logic                dp_n, show, blank_seg, lz, dp_bit;
   logic [3:0]          nib;
   int                  idx;

   // Phase within a slot is a pure function of slot tick and latched on-time.
   function automatic logic [1:0] phase(input logic [3:0] st, input logic [4:0] len);
      logic [4:0] s5;
      s5 = {1'b0, st};
      if (s5 < BT)             return S_BLANK;
      else if (s5 < BT + len)  return S_ON;
      else                     return S_OFF;
   endfunction

   // Active-low hex decode, bit order g..a.
   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   assign tick     = (presc_q == PW'(SCAN_DIV - 1));
   assign last_dig = (dig_q == IW'(DIGITS - 1));
   assign len_in   = ({1'b0, brightness} > MAX_L) ? MAX_L : {1'b0, brightness};

   // Sequencer next-state: prescaler, slot tick, digit index, FSM, frame latch.
   always_comb begin
      state_n = state_q;
      presc_n = presc_q;
      slot_n  = slot_q;
      dig_n   = dig_q;
      len_n   = len_q;
      fs_n    = 1'b0;
      if (!enable) begin
         state_n = S_IDLE;
         presc_n = '0;
         slot_n  = '0;
         dig_n   = '0;
         len_n   = '0;
      end else if (state_q == S_IDLE) begin
         presc_n = '0;
         slot_n  = '0;
         dig_n   = '0;
         len_n   = len_in;
         fs_n    = 1'b1;
         state_n = phase(4'd0, len_in);
      end else if (tick) begin
         presc_n = '0;
         if (slot_q == 4'd15) begin
            slot_n = '0;
            len_n  = len_in;
            dig_n  = last_dig ? '0 : dig_q + IW'(1);
            fs_n   = last_dig;
         end else begin
            slot_n = slot_q + 4'd1;
         end
         state_n = phase(slot_n, len_n);
      end else begin
         presc_n = presc_q + PW'(1);
      end
      val_n = fs_n ? value  : val_q;
      dpm_n = fs_n ? dpMask : dpm_q;
   end

   // Output decode from next-state values so anodes and segments switch on the same edge.
   always_comb begin
      idx       = int'(dig_n);
      nib       = val_n[idx*4 +: 4];
      dp_bit    = dpm_n[idx];
      seg_dec   = hex7(nib);
      show      = (state_n == S_ON);
      blank_seg = 1'b0;
`ifdef SM_SCAN_LEADING_ZERO_BLANK_EN
      lz = (nib == 4'h0) && (idx != 0);
      for (int i = 0; i < DIGITS; i++) begin
         if (i > idx && val_n[i*4 +: 4] != 4'h0) lz = 1'b0;
      end
`else
      lz = 1'b0;
`endif
      // A blanked leading zero with its dp set still lights, showing only the point.
      if (lz) begin
         if (dp_bit) blank_seg = 1'b1;
         else        show      = 1'b0;
      end
      an_n  = show ? ~(DIGITS'(1) << dig_n) : '1;
      seg_n = (show && !blank_seg) ? seg_dec : 7'h7F;
      dp_n  = show ? ~dp_bit : 1'b1;
   end

   // State, counters, shadow data and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         presc_q    <= '0;
         slot_q     <= '0;
         dig_q      <= '0;
         len_q      <= '0;
         val_q      <= '0;
         dpm_q      <= '0;
         anodes     <= '1;
         segments   <= 7'h7F;
         dp         <= 1'b1;
         frameStart <= 1'b0;
      end else begin
         state_q    <= state_n;
         presc_q    <= presc_n;
         slot_q     <= slot_n;
         dig_q      <= dig_n;
         len_q      <= len_n;
         val_q      <= val_n;
         dpm_q      <= dpm_n;
         anodes     <= an_n;
         segments   <= seg_n;
         dp         <= dp_n;
         frameStart <= fs_n;
      end
   end

   assign digitIndex = dig_q;

endmodule

// File: tb/tb_sm_display_scanner.sv
// Directed bench for sm_display_scanner with DIGITS=4, SCAN_DIV=4, BLANK_TICKS=2:
// one slot = 64 clk, one frame = 256 clk.
module tb_sm_display_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] value = 16'h1234;
   logic [3:0]  dpMask = 4'b0000;
   logic [3:0]  brightness = 4'd15;
   logic [6:0]  segments;
   logic        dp;
   logic [3:0]  anodes;
   logic [1:0]  digitIndex;
   logic        frameStart;

   int errors = 0;
   int checks = 0;

   logic [6:0] rec_seg [4];
   logic       rec_dp  [4];
   logic       rec_lit [4];
   int         low_cnt, fs_cnt, multi_cnt, idx_err;

   sm_display_scanner #(.DIGITS(4), .SCAN_DIV(4), .BLANK_TICKS(2)) dut (
      .clk(clk), .rst(rst), .enable(enable), .value(value), .dpMask(dpMask),
      .brightness(brightness), .segments(segments), .dp(dp), .anodes(anodes),
      .digitIndex(digitIndex), .frameStart(frameStart)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance past the current cycle, find the next frameStart, then record one full frame.
   task automatic scan_frame(input int change_at, input logic [15:0] new_val);
      logic found;
      int   d;
      found = 1'b0;
      for (int k = 0; k < 600; k++) begin
         step(1);
         if (frameStart) begin
            found = 1'b1;
            break;
         end
      end
      chk("fs_wait", {31'd0, found}, 32'd1);
      low_cnt = 0; fs_cnt = 0; multi_cnt = 0; idx_err = 0;
      for (int j = 0; j < 4; j++) begin
         rec_seg[j] = 7'h7F; rec_dp[j] = 1'b1; rec_lit[j] = 1'b0;
      end
      for (int i = 0; i < 256; i++) begin
         if (frameStart) fs_cnt++;
         d = -1;
         case (anodes)
            4'b1110: d = 0;
            4'b1101: d = 1;
            4'b1011: d = 2;
            4'b0111: d = 3;
            4'b1111: d = -1;
            default: multi_cnt++;
         endcase
         if (d >= 0) begin
            low_cnt++;
            rec_seg[d] = segments;
            rec_dp[d]  = dp;
            rec_lit[d] = 1'b1;
            if (int'(digitIndex) != d) idx_err++;
         end
         if (i == change_at) value = new_val;
         step(1);
      end
      chk("fs_period", {31'd0, frameStart}, 32'd1);
      chk("fs_count", fs_cnt, 1);
      chk("one_hot", multi_cnt, 0);
      chk("idx_match", idx_err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      #22;
      chk("rst_an", anodes, 4'hF);
      chk("rst_seg", segments, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_idx", digitIndex, 2'd0);
      chk("rst_fs", frameStart, 1'b0);
      rst = 1'b0;
      step(3);
      chk("idle_an", anodes, 4'hF);

      // Start-up timing from IDLE.
      enable = 1'b1;
      step(1);
      chk("start_fs", frameStart, 1'b1);
      chk("start_an", anodes, 4'hF);
      chk("start_idx", digitIndex, 2'd0);
      step(1);
      chk("start_fs_drop", frameStart, 1'b0);
      step(6);
      chk("blank_end_an", anodes, 4'hF);
      step(1);
      chk("d0_on_an", anodes, 4'b1110);
      chk("d0_seg", segments, 7'b0011001);
      chk("d0_dp", dp, 1'b1);
      step(55);
      chk("d0_last_an", anodes, 4'b1110);
      step(1);
      chk("d1_blank_an", anodes, 4'hF);
      chk("d1_idx", digitIndex, 2'd1);
      step(8);
      chk("d1_on_an", anodes, 4'b1101);
      chk("d1_seg", segments, 7'b0110000);

      // Mid-frame value change must not tear the current frame.
      scan_frame(100, 16'hABCD);
      chk("tear_d0", rec_seg[0], 7'b0011001);
      chk("tear_d1", rec_seg[1], 7'b0110000);
      chk("tear_d2", rec_seg[2], 7'b0100100);
      chk("tear_d3", rec_seg[3], 7'b1111001);
      chk("full_low", low_cnt, 4*14*4);
      scan_frame(-1, 16'h0);
      chk("new_d0", rec_seg[0], 7'b0100001);
      chk("new_d1", rec_seg[1], 7'b1000110);
      chk("new_d2", rec_seg[2], 7'b0000011);
      chk("new_d3", rec_seg[3], 7'b0001000);

      // Brightness PWM.
      value = 16'h1234;
      brightness = 4'd4;
      scan_frame(-1, 16'h0);
      chk("bri4_low", low_cnt, 4*4*4);
      brightness = 4'd0;
      scan_frame(-1, 16'h0);
      chk("bri0_low", low_cnt, 0);

      // Leading zeros with dp on the top digit.
      brightness = 4'd15;
      value = 16'h0050;
      dpMask = 4'b1000;
      scan_frame(-1, 16'h0);
      chk("lz_d0_seg", rec_seg[0], 7'b1000000);
      chk("lz_d0_dp", rec_dp[0], 1'b1);
      chk("lz_d1_seg", rec_seg[1], 7'b0010010);
      chk("lz_d3_lit", rec_lit[3], 1'b1);
      chk("lz_d3_dp", rec_dp[3], 1'b0);
`ifdef SM_SCAN_LEADING_ZERO_BLANK_EN
      chk("lz_d2_lit", rec_lit[2], 1'b0);
      chk("lz_d3_seg", rec_seg[3], 7'h7F);
`else
      chk("lz_d2_lit", rec_lit[2], 1'b1);
      chk("lz_d2_seg", rec_seg[2], 7'b1000000);
      chk("lz_d3_seg", rec_seg[3], 7'b1000000);
`endif

      // enable dropped during ON, then restart.
      value = 16'h1234;
      dpMask = 4'b0000;
      found = 1'b0;
      for (int k = 0; k < 600; k++) begin
         step(1);
         if (anodes != 4'hF) begin
            found = 1'b1;
            break;
         end
      end
      chk("on_wait", {31'd0, found}, 32'd1);
      enable = 1'b0;
      step(1);
      chk("dis_an", anodes, 4'hF);
      chk("dis_seg", segments, 7'h7F);
      step(5);
      chk("dis_idx", digitIndex, 2'd0);
      chk("dis_an_hold", anodes, 4'hF);
      value = 16'h5678;
      enable = 1'b1;
      step(1);
      chk("re_fs", frameStart, 1'b1);
      chk("re_idx", digitIndex, 2'd0);
      step(8);
      chk("re_an", anodes, 4'b1110);
      chk("re_seg", segments, 7'b0000000);

      // Asynchronous reset during ON.
      #2;
      rst = 1'b1;
      #1;
      chk("arst_an", anodes, 4'hF);
      chk("arst_seg", segments, 7'h7F);
      enable = 1'b0;
      step(2);
      rst = 1'b0;
      step(10);
      chk("post_rst_an", anodes, 4'hF);
      chk("post_rst_seg", segments, 7'h7F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
